// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, decodes Gray-code steps into an N-bit position.
// Optional error counter on err_cnt is built only when QDEC_ERR_CNT_EN is defined.
module quadrature_decoder #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  output logic [N-1:0] q,
  output logic         dir,
  output logic         step_tick,
  output logic         err_tick,
  output logic         max_tick,
  output logic         min_tick,
  output logic [7:0]   err_cnt
);

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             cur;
  logic [1:0]             prev;
  logic [WARM_W-1:0]      warm;
  logic                   armed;
  logic                   step_up;
  logic                   step_dn;
  logic                   illegal;
  logic [N-1:0]           q_next;
  logic                   dir_next;
  logic                   step_next;
  logic                   err_next;

  // Metastability synchronizers for the asynchronous encoder channels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
    end
  end

  assign cur = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Previous synchronized pair, tracked every cycle independent of en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 2'b00;
    end else begin
      prev <= cur;
    end
  end

  // Startup guard: decoding stays disarmed until the synchronizers hold real input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm <= '0;
    end else if (warm != WARM_W'(WARM_MAX)) begin
      warm <= warm + WARM_W'(1);
    end else begin
      warm <= warm;
    end
  end

  assign armed = (warm == WARM_W'(WARM_MAX));

  // Transition decode of {prev, cur}; a double-bit change is illegal
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    if (armed) begin
      case ({prev, cur})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up = 1'b1;
        4'b0010, 4'b1011, 4'b1101, 4'b0100: step_dn = 1'b1;
        4'b0011, 4'b0110, 4'b1001, 4'b1100: illegal = 1'b1;
        default: begin
          step_up = 1'b0;
          step_dn = 1'b0;
          illegal = 1'b0;
        end
      endcase
    end else begin
      illegal = 1'b0;
    end
  end

  // Count update: syn_clr beats load beats a step; illegal flagging ignores en
  always_comb begin
    q_next    = q;
    dir_next  = dir;
    step_next = 1'b0;
    err_next  = illegal;
    if (syn_clr) begin
      q_next   = {N{1'b0}};
      dir_next = 1'b1;
    end else if (load) begin
      q_next = d;
    end else if (en && step_up) begin
      q_next    = q + N'(1);
      dir_next  = 1'b1;
      step_next = 1'b1;
    end else if (en && step_dn) begin
      q_next    = q - N'(1);
      dir_next  = 1'b0;
      step_next = 1'b1;
    end else begin
      q_next = q;
    end
  end

  // Registered position, direction and tick outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= {N{1'b0}};
      dir       <= 1'b1;
      step_tick <= 1'b0;
      err_tick  <= 1'b0;
    end else begin
      q         <= q_next;
      dir       <= dir_next;
      step_tick <= step_next;
      err_tick  <= err_next;
    end
  end

  assign max_tick = (q == {N{1'b1}});
  assign min_tick = (q == {N{1'b0}});

`ifdef QDEC_ERR_CNT_EN
  logic [7:0] err_count;

  // Saturating count of illegal transitions, updated on the edge err_tick rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (syn_clr) begin
      err_count <= 8'd0;
    end else if (err_next && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end

  assign err_cnt = err_count;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed scenarios plus a randomized encoder walk,
// all compared cycle by cycle against a Gray-index arithmetic reference model.
module tb_quadrature_decoder;

  localparam int N   = 8;
  localparam int S   = 2;
  localparam int MOD = 1 << N;

  logic         clk;
  logic         reset;
  logic         a_in;
  logic         b_in;
  logic         syn_clr;
  logic         load;
  logic [N-1:0] d;
  logic         en;
  logic [N-1:0] q;
  logic         dir;
  logic         step_tick;
  logic         err_tick;
  logic         max_tick;
  logic         min_tick;
  logic [7:0]   err_cnt;

  quadrature_decoder #(.N(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .syn_clr(syn_clr), .load(load), .d(d), .en(en),
    .q(q), .dir(dir), .step_tick(step_tick), .err_tick(err_tick),
    .max_tick(max_tick), .min_tick(min_tick), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step_seen;
  int n_err_seen;

  // reference model state
  logic [1:0] hist[$];
  int         k_edges;
  int         m_q;
  int         m_dir;
  int         m_step;
  int         m_err;
  int         m_cnt;
  logic [1:0] cur_ab;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // position of a pair along the up sequence 00,01,11,10
  function automatic int gidx(input logic [1:0] x);
    return {30'd0, x[1], x[1] ^ x[0]};
  endfunction

  function automatic logic [1:0] gcode(input int i);
    logic [1:0] v;
    v = i[1:0];
    return {v[1], v[1] ^ v[0]};
  endfunction

  task automatic model_reset();
    hist.delete();
    k_edges = 0;
    m_q = 0; m_dir = 1; m_step = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [1:0] c;
    logic [1:0] p;
    int dlt;
    hist.push_front({a_in, b_in});
    if (hist.size() > S + 2) void'(hist.pop_back());
    k_edges++;
    c = (hist.size() > S)     ? hist[S]     : 2'b00;
    p = (hist.size() > S + 1) ? hist[S + 1] : 2'b00;
    dlt = (gidx(c) - gidx(p) + 4) % 4;
    if (k_edges <= S + 1) dlt = 0;
    m_step = 0;
    m_err  = (dlt == 2) ? 1 : 0;
    if (syn_clr) begin
      m_q = 0; m_dir = 1;
    end else if (load) begin
      m_q = int'(d);
    end else if (en && dlt == 1) begin
      m_q = (m_q + 1) % MOD; m_dir = 1; m_step = 1;
    end else if (en && dlt == 3) begin
      m_q = (m_q + MOD - 1) % MOD; m_dir = 0; m_step = 1;
    end
`ifdef QDEC_ERR_CNT_EN
    if (syn_clr) m_cnt = 0;
    else if (m_err == 1 && m_cnt < 255) m_cnt++;
`endif
  endtask

  task automatic check_all();
    check_eq("q", 32'(q), 32'(m_q));
    check_eq("dir", 32'(dir), 32'(m_dir));
    check_eq("step_tick", 32'(step_tick), 32'(m_step));
    check_eq("err_tick", 32'(err_tick), 32'(m_err));
    check_eq("max_tick", 32'(max_tick), (m_q == MOD - 1) ? 32'd1 : 32'd0);
    check_eq("min_tick", 32'(min_tick), (m_q == 0) ? 32'd1 : 32'd0);
    check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
    n_step_seen += int'(step_tick);
    n_err_seen  += int'(err_tick);
  endtask

  task automatic cyc(input logic [1:0] ab, input logic e, input logic ld,
                     input logic [N-1:0] dv, input logic cl);
    @(negedge clk);
    a_in = ab[1]; b_in = ab[0]; en = e; load = ld; d = dv; syn_clr = cl;
    cur_ab = ab;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [1:0] ab, input int n, input logic e, input logic ld,
                      input logic [N-1:0] dv, input logic cl);
    for (int i = 0; i < n; i++) cyc(ab, e, ld, dv, cl);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b1; a_in = ab[1]; b_in = ab[0]; cur_ab = ab;
    en = 1'b1; load = 1'b0; syn_clr = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a_in = 1'b0; b_in = 1'b0; en = 1'b1;
    load = 1'b0; syn_clr = 1'b0; d = '0; cur_ab = 2'b00;
    n_step_seen = 0; n_err_seen = 0;
    model_reset();

    // up sequence after reset
    do_reset(2'b00);
    n_step_seen = 0;
    hold(2'b00, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    hold(2'b01, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    hold(2'b11, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    hold(2'b10, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    hold(2'b00, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("up_seq_q", 32'(q), 32'd4);
    check_eq("up_seq_dir", 32'(dir), 32'd1);
    check_eq("up_seq_ticks", 32'(n_step_seen), 32'd4);

    // wrap down from 0 and up from max
    hold(2'b00, 1, 1'b1, 1'b1, 8'h00, 1'b0);
    hold(2'b10, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("wrap_dn_q", 32'(q), 32'hFF);
    check_eq("wrap_dn_max", 32'(max_tick), 32'd1);
    check_eq("wrap_dn_dir", 32'(dir), 32'd0);
    hold(2'b10, 1, 1'b1, 1'b1, 8'hFF, 1'b0);
    hold(2'b00, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("wrap_up_q", 32'(q), 32'h00);
    check_eq("wrap_up_min", 32'(min_tick), 32'd1);

    // illegal double transition
    n_err_seen = 0;
    hold(2'b11, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("illegal_ticks", 32'(n_err_seen), 32'd1);
    check_eq("illegal_q", 32'(q), 32'h00);
`ifdef QDEC_ERR_CNT_EN
    check_eq("illegal_cnt", 32'(err_cnt), 32'd1);
`else
    check_eq("illegal_cnt", 32'(err_cnt), 32'd0);
`endif

    // steps dropped while disabled
    n_step_seen = 0;
    hold(2'b10, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    hold(2'b00, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    hold(2'b01, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    hold(2'b01, 2, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("en_off_q", 32'(q), 32'h00);
    check_eq("en_off_ticks", 32'(n_step_seen), 32'd0);
    hold(2'b11, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("en_on_q", 32'(q), 32'h01);

    // load wins over a coincident step; syn_clr wins over load
    n_step_seen = 0;
    hold(2'b10, 4, 1'b1, 1'b1, 8'h55, 1'b0);
    check_eq("load_step_q", 32'(q), 32'h55);
    check_eq("load_step_ticks", 32'(n_step_seen), 32'd0);
    hold(2'b10, 1, 1'b1, 1'b1, 8'h12, 1'b1);
    check_eq("clr_load_q", 32'(q), 32'h00);
    check_eq("clr_load_dir", 32'(dir), 32'd1);

    // reset released with the encoder sitting at 11
    do_reset(2'b11);
    n_err_seen = 0; n_step_seen = 0;
    hold(2'b11, 6, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("start11_err", 32'(n_err_seen), 32'd0);
    check_eq("start11_q", 32'(q), 32'h00);
    hold(2'b10, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("start11_step_q", 32'(q), 32'h01);

    // randomized encoder walk with sporadic control events and resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] nab;
      r = $urandom_range(0, 99);
      if (r < 20)      nab = gcode(gidx(cur_ab) + 1);
      else if (r < 40) nab = gcode(gidx(cur_ab) + 3);
      else if (r < 43) nab = ~cur_ab;
      else             nab = cur_ab;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2'($urandom_range(0, 3)));
      end else begin
        cyc(nab, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
            N'($urandom), ($urandom_range(0, 79) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 SHALL have parameter N, default 8: position counter width in bits (N >= 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth per encoder input (>= 2).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a_in  input  1  encoder channel A, asynchronous to clk.
REQ-006 SHALL have port b_in  input  1  encoder channel B, asynchronous to clk.
REQ-007 SHALL have port syn_clr  input  1  synchronous clear of count and error state.
REQ-008 SHALL have port load  input  1  synchronous load of d into the count.
REQ-009 SHALL have port d  input  N  load value.
REQ-010 SHALL have port en  input  1  count enable; steps are ignored while low.
REQ-011 SHALL have port q  output  N  current position count.
REQ-012 SHALL have port dir  output  1  direction of the last valid step; 1 = up, 0 = down.
REQ-013 SHALL have port step_tick  output  1  one-cycle pulse in the cycle q changed due to a step.
REQ-014 SHALL have port err_tick  output  1  one-cycle pulse on an illegal (double) transition.
REQ-015 SHALL have port max_tick  output  1  high while q == 2**N-1.
REQ-016 SHALL have port min_tick  output  1  high while q == 0.
REQ-017 SHALL have port err_cnt  output  8  error count (see Configuration).

Function
REQ-018 SHALL pass a_in and b_in through a SYNC_STAGES-deep flip-flop synchronizer each; only the last stage feeds the decoder.
REQ-019 SHALL register the previous synchronized pair {A,B} (prev) every cycle, regardless of en.
REQ-020 SHALL decode up steps as {A,B} transitions 00->01, 01->11, 11->10, 10->00.
REQ-021 SHALL decode down steps as the reverse transitions 00->10, 10->11, 11->01, 01->00.
REQ-022 SHALL treat a pair equal to prev as no step; q, dir and both ticks are unchanged or low.
REQ-023 SHALL treat a transition where both bits change as illegal: err_tick = 1 for one cycle, q and dir are unchanged.
REQ-024 SHALL, on a valid step with en = 1, update q by +1 (up) or -1 (down) modulo 2**N, set dir accordingly and pulse step_tick in the same cycle.
REQ-025 SHALL wrap 2**N-1 + 1 -> 0 and 0 - 1 -> 2**N-1 without any additional flag beyond max_tick and min_tick.
REQ-026 SHALL, with en = 0, drop steps entirely (no deferred counting) and hold step_tick low, while still flagging illegal transitions on err_tick.
REQ-027 SHALL prioritize syn_clr over load, and load over a step; a step coincident with syn_clr or load is discarded and step_tick stays low.
REQ-028 SHALL, on syn_clr, set q = 0 and dir = 1; on load, set q = d with dir unchanged.
REQ-029 SHALL exhibit a latency of SYNC_STAGES+1 rising edges from an input change to the q, step_tick or err_tick update.
REQ-030 SHALL register step_tick and err_tick, and derive max_tick and min_tick combinationally from q.

Reset
REQ-031 SHALL, on reset, clear the synchronizers and prev to 0, q to 0, dir to 1, step_tick, err_tick and err_cnt to 0.
REQ-032 SHALL suppress step and error decoding for the first SYNC_STAGES+1 rising edges after reset deasserts while prev tracks the inputs, so a non-00 encoder state at startup causes no count and no err_tick.
REQ-033 SHALL abandon any in-flight transition when reset asserts mid-operation and emit no tick for it.

Configuration
REQ-034 SHALL, with macro QDEC_ERR_CNT_EN defined, drive err_cnt from an 8-bit counter that increments on each err_tick, saturates at 255 and is cleared by syn_clr or reset.
REQ-035 SHALL, without QDEC_ERR_CNT_EN, drive err_cnt constant 0 and contain no counter logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover: after reset, drive the up sequence 00,01,11,10,00 with each state held 4 cycles -> q = 4, dir = 1, four step_tick pulses, each SYNC_STAGES+1 edges after its input change.
REQ-037 SHALL cover: load d = 0x00 then one down step -> q = 0xFF, max_tick = 1, dir = 0; load d = 0xFF then one up step -> q = 0x00, min_tick = 1.
REQ-038 SHALL cover: from {A,B} = 00, jump to 11 in one cycle -> err_tick pulses once, q is unchanged, and err_cnt = 1 with QDEC_ERR_CNT_EN (0 without).
REQ-039 SHALL cover: en = 0 during 3 up steps then en = 1 -> q is unchanged and no step_tick occurs; a subsequent up step gives q + 1.
REQ-040 SHALL cover: load d = 0x55 asserted in the same cycle a step would register -> q = 0x55 and step_tick stays low; syn_clr together with load -> q = 0.
REQ-041 SHALL cover: reset released with a_in = b_in = 1 -> no err_tick and no count; then 11->10 -> q = 1.
